// File: rtl/spi_ram_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_responder_if
// Purpose  : SPI RAM bus pins (SCK, CS#, MOSI, MISO) with initiator/target views.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_ram_responder_if;
  logic spi_clk;
  logic spi_select;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_clk,
    output spi_select,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_clk,
    input  spi_select,
    input  spi_mosi,
    output spi_miso
  );
endinterface
`default_nettype wire

// File: rtl/spi_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_responder
// Purpose  : 23LC512-style serial SRAM target (READ 0x03 / WRITE 0x02,
//            sequential mode), oversampling the SPI pins on clk.
//            Optional backdoor port: define SPI_RAM_RESPONDER_BACKDOOR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_ram_responder #(
  parameter int ADDR_BITS = 16,
  parameter int MEM_BYTES = 256
) (
  input  wire logic              clk,
  input  wire logic              rst,
  spi_ram_responder_if.slave     spi,
  output logic                   busy,
  output logic                   cmd_error,
  output logic                   wr_strobe
`ifdef SPI_RAM_RESPONDER_BACKDOOR_EN
  ,
  input  wire logic                         bd_we,
  input  wire logic [$clog2(MEM_BYTES)-1:0] bd_addr,
  input  wire logic [7:0]                   bd_wdata,
  output logic      [7:0]                   bd_rdata
`endif
);

  localparam int c_ADDR_W     = $clog2(MEM_BYTES);
  localparam int c_ADDR_BYTES = ADDR_BITS / 8;
  localparam int c_ABYTE_W    = (c_ADDR_BYTES > 1) ? $clog2(c_ADDR_BYTES) : 1;
  localparam logic [7:0] c_CMD_READ  = 8'h03;
  localparam logic [7:0] c_CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_READ   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [1:0] r_sck_s;
  logic [1:0] r_sel_s;
  logic [1:0] r_mosi_s;
  logic       r_sck_d;
  logic       r_sel_d;

  logic [2:0]           r_bit_cnt;
  logic [c_ABYTE_W-1:0] r_abyte_cnt;
  logic [2:0]           r_out_cnt;
  logic [6:0]           r_shift_in;
  logic [7:0]           r_shift_out;
  logic [c_ADDR_W-1:0]  r_addr;
  logic                 r_is_read;
  logic                 r_miso;
  logic                 r_cmd_error;
  logic                 r_wr_strobe;

  logic [7:0] r_mem [MEM_BYTES];

  logic                w_deselected;
  logic                w_mosi;
  logic                w_rise;
  logic                w_fall;
  logic                w_sel_fall;
  logic                w_byte_done;
  logic [7:0]          w_byte_in;
  logic [c_ADDR_W-1:0] w_addr_shift;
  logic [c_ADDR_W-1:0] w_addr_inc;
  logic                w_cmd_err;
  logic                w_spi_we;
  logic                w_load_first;
  logic                w_load_next;

  // Select sync flops reset to "asserted" so a select already held low
  // across reset is not mistaken for a new falling edge.
  assign w_deselected = r_sel_s[1];
  assign w_mosi       = r_mosi_s[1];
  assign w_rise       = ~w_deselected &  r_sck_s[1] & ~r_sck_d;
  assign w_fall       = ~w_deselected & ~r_sck_s[1] &  r_sck_d;
  assign w_sel_fall   = r_sel_d & ~r_sel_s[1];
  assign w_byte_in    = {r_shift_in, w_mosi};
  assign w_byte_done  = w_rise & (r_bit_cnt == 3'd7);
  assign w_addr_shift = {r_addr[c_ADDR_W-2:0], w_mosi};
  assign w_addr_inc   = r_addr + c_ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cmd_err    = 1'b0;
    w_spi_we     = 1'b0;
    w_load_first = 1'b0;
    w_load_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_fall) begin
          w_state_next = ST_CMD;
        end
      end
      ST_CMD: begin
        if (w_byte_done) begin
          if ((w_byte_in == c_CMD_READ) || (w_byte_in == c_CMD_WRITE)) begin
            w_state_next = ST_ADDR;
          end else begin
            w_state_next = ST_IGNORE;
            w_cmd_err    = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (w_byte_done && (r_abyte_cnt == c_ABYTE_W'(c_ADDR_BYTES - 1))) begin
          w_state_next = r_is_read ? ST_READ : ST_WRITE;
          w_load_first = r_is_read;
        end
      end
      ST_READ: begin
        if (w_fall && (r_out_cnt == 3'd7)) begin
          w_load_next = 1'b1;
        end
      end
      ST_WRITE: begin
        if (w_byte_done) begin
          w_spi_we = 1'b1;
        end
      end
      ST_IGNORE: begin
        w_state_next = ST_IGNORE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    // Edges are gated by select, so no strobe can fire alongside a deselect.
    if ((r_state != ST_IDLE) && w_deselected) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_s     <= 2'b00;
      r_sel_s     <= 2'b00;
      r_mosi_s    <= 2'b00;
      r_sck_d     <= 1'b0;
      r_sel_d     <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_abyte_cnt <= '0;
      r_out_cnt   <= 3'd0;
      r_shift_in  <= 7'd0;
      r_shift_out <= 8'd0;
      r_addr      <= '0;
      r_is_read   <= 1'b0;
      r_miso      <= 1'b0;
      r_cmd_error <= 1'b0;
      r_wr_strobe <= 1'b0;
    end else begin
      r_sck_s     <= {r_sck_s[0], spi.spi_clk};
      r_sel_s     <= {r_sel_s[0], spi.spi_select};
      r_mosi_s    <= {r_mosi_s[0], spi.spi_mosi};
      r_sck_d     <= r_sck_s[1];
      r_sel_d     <= r_sel_s[1];
      r_cmd_error <= w_cmd_err;
      r_wr_strobe <= w_spi_we;

      if (r_state == ST_IDLE) begin
        r_bit_cnt   <= 3'd0;
        r_abyte_cnt <= '0;
        r_out_cnt   <= 3'd0;
        r_shift_out <= 8'd0;
        r_miso      <= 1'b0;
      end else begin
        if (w_rise) begin
          r_shift_in <= w_byte_in[6:0];
          r_bit_cnt  <= r_bit_cnt + 3'd1;
        end
        if ((r_state == ST_CMD) && w_byte_done) begin
          r_is_read <= (w_byte_in == c_CMD_READ);
        end
        if ((r_state == ST_ADDR) && w_rise) begin
          r_addr <= w_addr_shift;
          if (r_bit_cnt == 3'd7) begin
            r_abyte_cnt <= r_abyte_cnt + c_ABYTE_W'(1);
          end
        end
        if (w_load_first) begin
          r_shift_out <= r_mem[w_addr_shift];
          r_out_cnt   <= 3'd0;
        end
        if ((r_state == ST_READ) && w_fall) begin
          r_miso    <= r_shift_out[7];
          r_out_cnt <= r_out_cnt + 3'd1;
          if (w_load_next) begin
            r_addr      <= w_addr_inc;
            r_shift_out <= r_mem[w_addr_inc];
          end else begin
            r_shift_out <= {r_shift_out[6:0], 1'b0};
          end
        end
        if (w_spi_we) begin
          r_addr <= w_addr_inc;
        end
        if (w_state_next == ST_IDLE) begin
          r_miso <= 1'b0;
        end
      end
    end
  end

  // Storage is deliberately not reset; only committed SPI bytes or
  // backdoor writes change it.
  always_ff @(posedge clk) begin
    if (w_spi_we) begin
      r_mem[r_addr] <= w_byte_in;
    end
`ifdef SPI_RAM_RESPONDER_BACKDOOR_EN
    else if (bd_we) begin
      r_mem[bd_addr] <= bd_wdata;
    end
`endif
  end

`ifdef SPI_RAM_RESPONDER_BACKDOOR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bd_rdata <= 8'd0;
    end else begin
      bd_rdata <= r_mem[bd_addr];
    end
  end
`endif

  assign spi.spi_miso = r_miso;
  assign busy         = (r_state != ST_IDLE) & ~w_deselected;
  assign cmd_error    = r_cmd_error;
  assign wr_strobe    = r_wr_strobe;

endmodule
`default_nettype wire
